// File: rtl/obi_mem_pipelined.sv
// Single-port OBI slave memory with a configurable read latency, in-order pipelined responses
// and out-of-range error responses. Define MEM_STALL_EN to add pseudo-random grant wait states.
module obi_mem_pipelined #(
  parameter int unsigned SIZE       = 16384,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LATENCY    = 1,
  parameter string       INIT_FILE  = ""
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req,
  output logic                    gnt,
  input  logic [31:0]             addr,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic                    rvalid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    err
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned WORDS = SIZE / NB;
  localparam int unsigned AW    = $clog2(SIZE);
  localparam int unsigned OW    = $clog2(NB);

  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic [DATA_WIDTH-1:0] data;
  } resp_t;

  logic [DATA_WIDTH-1:0] mem [WORDS];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [AW-OW-1:0]      word_idx;
  logic                  in_range;
  logic                  accept;
  logic                  head_rd_d, head_rd_q;
  resp_t                 pipe_d [LATENCY];
  resp_t                 pipe_q [LATENCY];
  resp_t                 stage  [LATENCY];

  // Any address bit at or above bit AW makes the access out of range.
  assign in_range = addr < SIZE;
  assign word_idx = addr[AW-1:OW];

`ifdef MEM_STALL_EN
  logic [7:0] lfsr_d, lfsr_q;

  // Fibonacci LFSR, taps 8,6,5,4.
  always_comb lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 8'hA5;
    else        lfsr_q <= lfsr_d;
  end

  assign gnt = req && (lfsr_q[1:0] != 2'b00);
`else
  assign gnt = req;
`endif

  assign accept = req && gnt;

  // NOTE: the array and its read register have no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (accept && we && in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[word_idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    rd_data_q <= mem[word_idx];
  end

  // Stage 0 carries only the flags; its data comes straight from the RAM read register.
  always_comb begin
    head_rd_d = accept && !we && in_range;
    pipe_d[0] = '{valid: accept, err: accept && !in_range, data: '0};
    for (int i = 0; i < LATENCY; i++) stage[i] = pipe_q[i];
    stage[0].data = head_rd_q ? rd_data_q : '0;
    for (int i = 1; i < LATENCY; i++) pipe_d[i] = stage[i-1];
  end

  // NOTE: sequential state uses non-blocking assignments so every stage shifts on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
      head_rd_q <= 1'b0;
    end else begin
      pipe_q    <= pipe_d;
      head_rd_q <= head_rd_d;
    end
  end

  assign rvalid = stage[LATENCY-1].valid;
  assign err    = stage[LATENCY-1].valid && stage[LATENCY-1].err;
  assign rdata  = stage[LATENCY-1].valid ? stage[LATENCY-1].data : '0;

endmodule

// File: tb/tb_obi_mem_pipelined.sv
// Bench for obi_mem_pipelined: three instances (LATENCY 1, 3, 4) share one stimulus stream and
// are scored against a word-array memory model with per-instance expected-response queues.
module tb_obi_mem_pipelined;

  localparam int unsigned SIZE = 16384;
`ifdef MEM_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        clk, rst_n, req, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic [2:0]  gnt_v, rvalid_v, err_v;
  logic [31:0] rdata_v [3];

  obi_mem_pipelined #(.SIZE(SIZE), .DATA_WIDTH(32), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_v[0]), .addr(addr), .we(we), .be(be),
    .wdata(wdata), .rvalid(rvalid_v[0]), .rdata(rdata_v[0]), .err(err_v[0]));
  obi_mem_pipelined #(.SIZE(SIZE), .DATA_WIDTH(32), .LATENCY(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_v[1]), .addr(addr), .we(we), .be(be),
    .wdata(wdata), .rvalid(rvalid_v[1]), .rdata(rdata_v[1]), .err(err_v[1]));
  obi_mem_pipelined #(.SIZE(SIZE), .DATA_WIDTH(32), .LATENCY(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_v[2]), .addr(addr), .we(we), .be(be),
    .wdata(wdata), .rvalid(rvalid_v[2]), .rdata(rdata_v[2]), .err(err_v[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_vec = 0;
  int          n_miss = 0;
  int          k = 0;
  int          rv_cnt [3];
  logic [7:0]  lfsr_m;
  logic [31:0] mdl [int];
  exp_t        q0 [$];
  exp_t        q1 [$];
  exp_t        q2 [$];
  vec_t        tab [$];

  function automatic int lat_of(input int j);
    return (j == 0) ? 1 : ((j == 1) ? 3 : 4);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at edge %0d: got %h, expected %h", name, k, act, exp);
    end
  endtask

  task automatic push_resp(input logic e, input logic [31:0] d);
    exp_t x;
    x.err = e; x.data = d;
    x.due = k + lat_of(0) - 1; q0.push_back(x);
    x.due = k + lat_of(1) - 1; q1.push_back(x);
    x.due = k + lat_of(2) - 1; q2.push_back(x);
  endtask

  task automatic pop_due(input int j, output logic hit, output exp_t x);
    hit = 1'b0;
    x   = '{0, 1'b0, 32'h0};
    case (j)
      0: if (q0.size() > 0 && q0[0].due == k) begin hit = 1'b1; x = q0.pop_front(); end
      1: if (q1.size() > 0 && q1[0].due == k) begin hit = 1'b1; x = q1.pop_front(); end
      default: if (q2.size() > 0 && q2[0].due == k) begin hit = 1'b1; x = q2.pop_front(); end
    endcase
  endtask

  task automatic check_outputs();
    logic hit;
    exp_t x;
    for (int j = 0; j < 3; j++) begin
      pop_due(j, hit, x);
      if (rvalid_v[j]) rv_cnt[j]++;
      check($sformatf("resp_lat%0d", lat_of(j)), {30'h0, rvalid_v[j], err_v[j], rdata_v[j]},
            {30'h0, hit, hit && x.err, hit ? x.data : 32'h0});
    end
  endtask

  // Reference memory: word array, read-before-write, byte-enabled writes, range check on addr.
  task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] b, output logic e, output logic [31:0] rd);
    int          widx;
    logic [31:0] word;
    e  = 1'b0;
    rd = 32'h0;
    widx = int'(a / 4);
    if (a >= SIZE) begin
      e = 1'b1;
    end else if (w) begin
      word = mdl.exists(widx) ? mdl[widx] : 32'h0;
      for (int i = 0; i < 4; i++) if (b[i]) word[i*8 +: 8] = d[i*8 +: 8];
      mdl[widx] = word;
    end else begin
      rd = mdl[widx];
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, input logic use_tab, input logic tab_err,
                      input logic [31:0] tab_data, output logic acc);
    logic        exp_g, e;
    logic [31:0] rd;
    req = r; we = w; addr = a; wdata = d; be = b;
    #1;
    exp_g = r && (!STALL || (lfsr_m[1:0] != 2'b00));
    check("gnt", {61'h0, gnt_v}, {61'h0, {3{exp_g}}});
    acc = exp_g;
    @(posedge clk);
    k++;
    if (rst_n) lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    if (acc) begin
      model_access(w, a, d, b, e, rd);
      if (use_tab) push_resp(tab_err, tab_data);
      else         push_resp(e, rd);
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    logic acc;
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, acc);
  endtask

  // Holds the request stable until it is granted.
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                      input logic use_tab, input logic tab_err, input logic [31:0] tab_data);
    logic acc;
    acc = 1'b0;
    for (int t = 0; t < 64 && !acc; t++) step(1'b1, w, a, d, b, use_tab, tab_err, tab_data, acc);
    check("granted_within_64", {63'h0, acc}, 64'h1);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    req   = 1'b0;
    #1;
    for (int j = 0; j < 3; j++)
      check($sformatf("async_rst_lat%0d", lat_of(j)), {30'h0, rvalid_v[j], err_v[j], rdata_v[j]}, 64'h0);
    q0.delete(); q1.delete(); q2.delete();
    lfsr_m = 8'hA5;
    @(posedge clk);
    k++;
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
  endtask

  initial begin
    logic        acc;
    int          n_acc, widx;
    int          rv_base [3];
    logic [31:0] a;

    rst_n = 1'b0; req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
    lfsr_m = 8'hA5;
    for (int j = 0; j < 3; j++) rv_cnt[j] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int j = 0; j < 3; j++)
      check($sformatf("reset_state_lat%0d", lat_of(j)), {30'h0, rvalid_v[j], err_v[j], rdata_v[j]}, 64'h0);
    rst_n = 1'b1;

    // Preload the first 64 words so every later read has a known model value.
    for (int i = 0; i < 64; i++) xact(1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0, 1'b0, 32'h0);

    tab.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0});
    tab.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'h0, 1'b0, 32'hDEAD_BEEF});
    tab.push_back('{1'b1, 32'h0000_0010, 32'h1122_3344, 4'h5, 1'b0, 32'h0});
    tab.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'h0, 1'b0, 32'hDE22_BE44});
    tab.push_back('{1'b0, 32'h0000_0013, 32'h0,         4'h0, 1'b0, 32'hDE22_BE44});
    tab.push_back('{1'b1, 32'h0000_0000, 32'h0,         4'hF, 1'b0, 32'h0});
    tab.push_back('{1'b1, 32'h0000_4000, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0});
    tab.push_back('{1'b0, 32'h0000_0000, 32'h0,         4'h0, 1'b0, 32'h0});
    tab.push_back('{1'b0, 32'h0000_4000, 32'h0,         4'h0, 1'b1, 32'h0});
    tab.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 1'b1, 32'h0});
    tab.push_back('{1'b1, 32'h0000_0000, 32'h1,         4'hF, 1'b0, 32'h0});
    tab.push_back('{1'b1, 32'h0000_0004, 32'h2,         4'hF, 1'b0, 32'h0});
    tab.push_back('{1'b1, 32'h0000_0008, 32'h3,         4'hF, 1'b0, 32'h0});
    tab.push_back('{1'b1, 32'h0000_000C, 32'h4,         4'hF, 1'b0, 32'h0});
    tab.push_back('{1'b0, 32'h0000_0000, 32'h0,         4'h0, 1'b0, 32'h1});
    tab.push_back('{1'b0, 32'h0000_0004, 32'h0,         4'h0, 1'b0, 32'h2});
    tab.push_back('{1'b0, 32'h0000_0008, 32'h0,         4'h0, 1'b0, 32'h3});
    tab.push_back('{1'b0, 32'h0000_000C, 32'h0,         4'h0, 1'b0, 32'h4});
    for (int i = 0; i < tab.size(); i++)
      xact(tab[i].we, tab[i].addr, tab[i].wdata, tab[i].be, 1'b1, tab[i].exp_err, tab[i].exp_rdata);
    repeat (4) idle();

    // Randomised traffic, mostly in range with occasional out-of-range addresses.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0:       a = SIZE + $urandom_range(0, SIZE * 4);
        1:       a = {1'b1, 31'($urandom)};
        default: a = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
      endcase
      xact(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 1'b0, 1'b0, 32'h0);
      if ($urandom_range(0, 3) == 0) idle();
    end
    repeat (4) idle();

    // Request held high for 200 cycles of sequential reads.
    for (int j = 0; j < 3; j++) rv_base[j] = rv_cnt[j];
    n_acc = 0;
    widx  = 0;
    for (int c = 0; c < 200; c++) begin
      step(1'b1, 1'b0, 32'(widx * 4), 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, acc);
      if (acc) begin
        n_acc++;
        widx = (widx + 1) % 64;
      end
    end
    repeat (4) idle();
    for (int j = 0; j < 3; j++)
      check($sformatf("pulses_vs_accepts_lat%0d", lat_of(j)), 64'(rv_cnt[j] - rv_base[j]), 64'(n_acc));
    if (STALL) check("some_wait_states", {63'h0, n_acc < 200}, 64'h1);
    else       check("no_wait_states", 64'(n_acc), 64'd200);

    // Reset while two reads are in flight in the LATENCY=4 pipeline.
    for (int j = 0; j < 3; j++) rv_base[j] = rv_cnt[j];
    xact(1'b0, 32'h0000_0014, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    xact(1'b0, 32'h0000_0018, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    idle();
    pulse_reset();
    repeat (6) idle();
    check("l4_dropped_in_flight", 64'(rv_cnt[2] - rv_base[2]), 64'h0);
    xact(1'b0, 32'h0000_001C, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    repeat (5) idle();

    check("queues_drained", 64'(q0.size() + q1.size() + q2.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
